// File: rtl/grf_writeback_pkg.sv
// grf_writeback_pkg
//   Shared constants for the general register file and its neighbours
//   (the write-address select uses GRF_RA_REG as its link destination).
//   No ports; imported with `import grf_writeback_pkg::*;`.
package grf_writeback_pkg;

  // Register index that always reads as zero and is never written.
  localparam logic [4:0]  GRF_ZERO_REG  = 5'd0;
  // Link register: destination of jal / jalr PC+8 writes.
  localparam logic [4:0]  GRF_RA_REG    = 5'd31;
  // The link register is the highest architectural index, so the file size
  // follows from it.
  localparam int          GRF_NUM_REGS  = int'(GRF_RA_REG) + 1;
  // Value every writable register takes on reset.
  localparam logic [31:0] GRF_RESET_VAL = 32'h0000_0000;

endpackage : grf_writeback_pkg

// File: rtl/grf_bypass_read.sv
// grf_bypass_read
//   One combinational read port of the register file. Priority:
//   index 0 reads zero, then a same-cycle committed write to the same index
//   is forwarded, otherwise the stored value is returned.
// Ports:
//   raddr      in   read index
//   waddr      in   write index currently presented by write-back
//   wr_en      in   qualified write strobe (we && waddr != 0, X-safe)
//   wdata      in   write data currently presented by write-back
//   store_data in   storage contents at raddr
//   rdata      out  read result
module grf_bypass_read
  import grf_writeback_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = store_data;
    if (raddr == ADDR_W'(GRF_ZERO_REG)) begin
      rdata = '0;
    end else if (wr_en && (waddr == raddr)) begin
      // Write-back and decode share this cycle: forward the new value.
      rdata = wdata;
    end
  end

endmodule : grf_bypass_read

// File: rtl/grf_writeback.sv
// grf_writeback
//   General register file for the 5-stage MIPS pipeline. 31 writable
//   registers plus a hardwired-zero $0, two combinational read ports with
//   write-to-read bypass, and a registered write-trace record.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   we           in   write enable from write-back
//   waddr        in   write register index
//   wdata        in   write data
//   wpc          in   PC of the writing instruction (trace only)
//   raddr1/2     in   read indices (rs / rt)
//   rdata1/2     out  read data
//   trace_valid  out  pulse: a committed write occurred in the previous cycle
//   trace_pc     out  PC of the traced write
//   trace_addr   out  register index of the traced write
//   trace_data   out  data of the traced write
module grf_writeback
  import grf_writeback_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = $clog2(GRF_NUM_REGS),
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(GRF_RESET_VAL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [31:0]       wpc,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              trace_valid,
  output logic [31:0]       trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              wr_en;
  logic              trace_valid_q, trace_valid_d;
  logic [31:0]       trace_pc_q,    trace_pc_d;
  logic [ADDR_W-1:0] trace_addr_q,  trace_addr_d;
  logic [DATA_W-1:0] trace_data_q,  trace_data_d;

  // Qualified write strobe. Written as an if so that an unknown waddr (or we)
  // falls through to "no write" in simulation instead of corrupting state.
  always_comb begin
    wr_en = 1'b0;
    if (we && (waddr != ADDR_W'(GRF_ZERO_REG))) begin
      wr_en = 1'b1;
    end
  end

  // Next storage state. Entry 0 is pinned to zero so it folds away.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Trace record: capture on a committed write, otherwise hold the fields.
  always_comb begin
    trace_valid_d = 1'b0;
    trace_pc_d    = trace_pc_q;
    trace_addr_d  = trace_addr_q;
    trace_data_d  = trace_data_q;
    if (wr_en) begin
      trace_valid_d = 1'b1;
      trace_pc_d    = wpc;
      trace_addr_d  = waddr;
      trace_data_d  = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q[0] <= '0;
      for (int i = 1; i < NREG; i++) begin
        regs_q[i] <= RESET_VAL;
      end
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      regs_q        <= regs_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_addr_q  <= trace_addr_d;
      trace_data_q  <= trace_data_d;
    end
  end

  // Two identical read ports.
  logic [ADDR_W-1:0] raddr_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];

  assign raddr_arr[0] = raddr1;
  assign raddr_arr[1] = raddr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      grf_bypass_read #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_rd (
        .raddr      (raddr_arr[gi]),
        .waddr      (waddr),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .store_data (regs_q[raddr_arr[gi]]),
        .rdata      (rdata_arr[gi])
      );
    end
  endgenerate

  assign rdata1      = rdata_arr[0];
  assign rdata2      = rdata_arr[1];
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule : grf_writeback

// File: tb/tb_grf_writeback.sv
// tb_grf_writeback
//   Directed-vector bench for grf_writeback. Inputs change 1 ns after the
//   rising edge; combinational reads are checked 1 ns after inputs settle,
//   registered results 1 ns after the following edge.
module tb_grf_writeback;
  import grf_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] wpc;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  grf_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .wpc         (wpc),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_trace(input string tag, input logic v, input logic [31:0] pc,
                             input logic [4:0] a, input logic [31:0] d);
    check_vec({tag, ".valid"}, {31'd0, trace_valid}, {31'd0, v});
    check_vec({tag, ".pc"},    trace_pc,             pc);
    check_vec({tag, ".addr"},  {27'd0, trace_addr},  {27'd0, a});
    check_vec({tag, ".data"},  trace_data,           d);
  endtask

  initial begin
    reset  = 1'b1;
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    wpc    = '0;
    raddr1 = '0;
    raddr2 = '0;

    // Reset then read every index on both ports.
    tick();
    reset = 1'b0;
    for (int i = 0; i < GRF_NUM_REGS; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(GRF_NUM_REGS - 1 - i);
      #1;
      check_vec($sformatf("rst.r1[%0d]", i), rdata1, 32'h0);
      check_vec($sformatf("rst.r2[%0d]", GRF_NUM_REGS - 1 - i), rdata2, 32'h0);
    end
    check_trace("rst.trace", 1'b0, 32'h0, 5'd0, 32'h0);

    // Write and read back.
    we = 1'b1; waddr = 5'd8; wdata = 32'hDEAD_BEEF; wpc = 32'h0000_3000;
    raddr1 = 5'd8; raddr2 = 5'd7;
    #1;
    check_vec("wr8.bypass", rdata1, 32'hDEAD_BEEF);
    check_vec("wr8.other",  rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check_vec("wr8.store", rdata1, 32'hDEAD_BEEF);
    check_trace("wr8.trace", 1'b1, 32'h0000_3000, 5'd8, 32'hDEAD_BEEF);
    tick();
    check_trace("wr8.idle", 1'b0, 32'h0000_3000, 5'd8, 32'hDEAD_BEEF);

    // Write to $0: no bypass, no storage, no trace.
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; wpc = 32'h0000_3004;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check_vec("r0.same1", rdata1, 32'h0);
    check_vec("r0.same2", rdata2, 32'h0);
    tick();
    we = 1'b0;
    #1;
    check_vec("r0.after", rdata1, 32'h0);
    check_vec("r0.tvalid", {31'd0, trace_valid}, 32'h0);

    // Same-cycle bypass on both ports.
    we = 1'b1; waddr = 5'd5; wdata = 32'd1; wpc = 32'h0000_3010;
    tick();
    we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    check_vec("byp.pre1", rdata1, 32'd1);
    check_vec("byp.pre2", rdata2, 32'd1);
    we = 1'b1; wdata = 32'd7; wpc = 32'h0000_3014;
    #1;
    check_vec("byp.same1", rdata1, 32'd7);
    check_vec("byp.same2", rdata2, 32'd7);
    tick();
    we = 1'b0;
    #1;
    check_vec("byp.next1", rdata1, 32'd7);
    check_vec("byp.next2", rdata2, 32'd7);
    check_trace("byp.trace", 1'b1, 32'h0000_3014, 5'd5, 32'd7);

    // Back-to-back link writes to $31.
    we = 1'b1; waddr = GRF_RA_REG; wdata = 32'h0000_3008; wpc = 32'h0000_3000;
    tick();
    wdata = 32'h0000_3010; wpc = 32'h0000_3008;
    #1;
    check_trace("b2b.n1", 1'b1, 32'h0000_3000, 5'd31, 32'h0000_3008);
    tick();
    we = 1'b0; raddr1 = 5'd31;
    #1;
    check_trace("b2b.n2", 1'b1, 32'h0000_3008, 5'd31, 32'h0000_3010);
    check_vec("b2b.reg31", rdata1, 32'h0000_3010);
    tick();
    check_vec("b2b.idle", {31'd0, trace_valid}, 32'h0);

    // Reset mid-stream with a write presented in the same cycle.
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_00AA; wpc = 32'h0000_3020;
    tick();
    reset = 1'b1; wdata = 32'd5; wpc = 32'h0000_3024; raddr1 = 5'd9; raddr2 = 5'd8;
    #1;
    check_vec("mrst.byp9", rdata1, 32'd5);
    check_vec("mrst.old8", rdata2, 32'hDEAD_BEEF);
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    check_vec("mrst.reg9", rdata1, 32'h0);
    check_vec("mrst.reg8", rdata2, 32'h0);
    check_trace("mrst.trace", 1'b0, 32'h0, 5'd0, 32'h0);
    raddr1 = 5'd31; raddr2 = 5'd5;
    #1;
    check_vec("mrst.reg31", rdata1, 32'h0);
    check_vec("mrst.reg5",  rdata2, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_grf_writeback

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- General register file for the 5-stage MIPS pipeline; the write-back-side consumer of the register write-address and write-data selections.
- Holds 31 writable 32-bit registers; $0 is hardwired to zero.
- Provides two combinational read ports for the decode stage, with internal write-to-read bypass so that write-back and decode can share a cycle.
- Emits a registered write-trace record for the course grading log (PC, register, data).

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register index width (32 architectural registers).
- RESET_VAL, 32'h0000_0000, value loaded into every register on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable from the write-back stage.
- waddr  input  ADDR_W  write register index (rd / rt / 31 as selected upstream).
- wdata  input  DATA_W  write data (ALU / memory / PC+8 link as selected upstream).
- wpc  input  32  PC of the instruction performing the write (trace only).
- raddr1  input  ADDR_W  read port 1 index (rs).
- raddr2  input  ADDR_W  read port 2 index (rt).
- rdata1  output  DATA_W  read port 1 data.
- rdata2  output  DATA_W  read port 2 data.
- trace_valid  output  1  one-cycle pulse: a committed write occurred in the previous cycle.
- trace_pc  output  32  PC of the traced write.
- trace_addr  output  ADDR_W  register index of the traced write.
- trace_data  output  DATA_W  data of the traced write.

Behaviour:
- Reset (synchronous, on a clk rising edge with reset=1):
  - all registers 1..31 are set to RESET_VAL;
  - trace_valid=0, trace_pc=0, trace_addr=0, trace_data=0;
  - any write presented in the same cycle is discarded and not traced.
- Write:
  - on a rising edge with reset=0, we=1 and waddr!=0, reg[waddr] is set to wdata;
  - writes with waddr=0 leave storage unchanged.
- Read:
  - combinational; rdataN = 0 if raddrN=0;
  - else wdata if we=1 and waddr=raddrN;
  - else reg[raddrN].
  - Bypass applies to both ports independently and simultaneously (raddr1=raddr2=waddr returns wdata on both).
  - During the reset cycle, reads still follow the pre-reset storage plus bypass rule; after the reset edge they return RESET_VAL.
- Trace:
  - on a rising edge with reset=0, trace_valid is set to (we && waddr!=0);
  - when valid, trace_pc/addr/data capture wpc/waddr/wdata; otherwise they hold their previous values.
  - Latency from write to trace is exactly 1 cycle.
  - Back-to-back writes produce back-to-back trace pulses with no drop.
- Arithmetic: none. Widths are exact and there is no sign handling; stored data is written verbatim.
- X handling: if we=1 and waddr contains X, the write is ignored and no trace pulse is produced (guarded compare).

Decomposition:
- Shared macro file holds:
  - GRF_ZERO_REG (5'd0);
  - GRF_RA_REG (5'd31), matching the link write-address constant already used by the write-address select;
  - GRF_NUM_REGS (32);
  - GRF_RESET_VAL.
- One natural sub-module, grf_bypass_read: combinational per-port zero/bypass/storage select, instantiated twice. Storage, write logic and trace register stay in the top module.

Test Plan:
- Reset then read: assert reset 1 cycle, read all indices 0..31 -> every rdata=0, trace_valid=0.
- Write and read back: we=1, waddr=8, wdata=32'hDEAD_BEEF, wpc=32'h0000_3000 -> next cycle reg[8] reads DEAD_BEEF; trace_valid=1, trace_pc=3000, trace_addr=8, trace_data=DEAD_BEEF; following idle cycle trace_valid=0.
- $0 write: we=1, waddr=0, wdata=32'h1234_5678 -> rdata for raddr 0 stays 0, even in the same cycle (no bypass); trace_valid stays 0.
- Same-cycle bypass: reg[5]=1; present we=1, waddr=5, wdata=7 with raddr1=raddr2=5 -> both rdata=7 in that cycle; next cycle both still 7.
- Back-to-back link write: cycle N writes 31<=32'h0000_3008 (pc 3000), cycle N+1 writes 31<=32'h0000_3010 (pc 3008) -> trace pulses in N+1 and N+2 with the matching pc/data; reg[31]=3010 afterwards.
- Reset mid-stream: reset=1 together with we=1, waddr=9, wdata=5 -> reg[9]=0 after the edge; no trace pulse; trace fields 0.
